// File: rtl/ifq_pkg.sv
// ifq_pkg: shared widths, reset PC, queue entry type and PC-to-ROM address mapping.
package ifq_pkg;
    localparam int PC_W       = 32;
    localparam int DATA_W     = 32;
    localparam int ROM_ADRS_W = 9;

    // MIPS text segment base
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] data;
    } ifq_entry_t;

    // ROM is word addressed and only 512 words deep: the upper PC bits are dropped
    function automatic logic [ROM_ADRS_W-1:0] pc_to_adrs(input logic [PC_W-1:0] pc);
        return pc[ROM_ADRS_W+1:2];
    endfunction
endpackage

// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: ROM read port, redirect request and decode-side handshake.
// master = fetch unit, slave = surrounding core (ROM, branch unit, decoder).
interface ifetch_queue_if;
    import ifq_pkg::*;

    logic [ROM_ADRS_W-1:0] rom_adrs;
    logic [DATA_W-1:0]     rom_dout;
    logic                  redirect_valid;
    logic [PC_W-1:0]       redirect_pc;
    logic                  inst_valid;
    logic [DATA_W-1:0]     inst_data;
    logic [PC_W-1:0]       inst_pc;
    logic                  inst_ready;

    modport master (
        output rom_adrs, inst_valid, inst_data, inst_pc,
        input  rom_dout, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  rom_adrs, inst_valid, inst_data, inst_pc,
        output rom_dout, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/ifq_fifo.sv
// ifq_fifo: in-order {pc, data} queue with flush; DEPTH must be a power of two.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  ifq_entry_t                   i_wdata,
    input  logic                         i_pop,
    output ifq_entry_t                   o_rdata,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    ifq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rd;
    logic [PTR_W-1:0]  r_wr;
    logic [CNT_W-1:0]  r_count;

    // Storage array: no reset needed, validity is tracked by r_count
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_wr] <= i_wdata;
    end

    // Pointers and occupancy; flush empties the queue like reset
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_wr <= r_wr + PTR_W'(1);
            if (i_pop)
                r_rd <= r_rd + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC, one ROM read per cycle into an in-order queue,
// redirect with full flush. Optional IFQ_BYPASS_EN presents the ROM word
// directly when the queue is empty (zero fetch latency).
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic          clk,
    input logic          rst_n,
    ifetch_queue_if.master bus
);
    logic [PC_W-1:0]            r_fetch_pc;
    ifq_entry_t                 w_head;
    logic [$clog2(DEPTH+1)-1:0] w_count;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_fifo_pop;
    logic                       w_push;
    logic                       w_adv;
    logic                       w_unused;

    // Redirect targets are word aligned; the low two bits are ignored
    assign w_unused = ^{bus.redirect_pc[1:0], w_count};

    // A pop during redirect is irrelevant: the flush discards the queue anyway
    assign w_fifo_pop = !w_empty && bus.inst_ready && !bus.redirect_valid;

`ifdef IFQ_BYPASS_EN
    logic w_byp;
    logic w_byp_take;

    // Empty queue: head comes straight from the ROM at the current fetch PC
    assign w_byp      = w_empty && !bus.redirect_valid;
    assign w_byp_take = w_byp && bus.inst_ready;
    assign w_push     = !bus.redirect_valid && !w_byp_take && (!w_full || w_fifo_pop);
    assign w_adv      = w_push || w_byp_take;

    // Head select: queue first, then bypassed ROM word, else idle zeros
    always_comb begin
        bus.inst_valid = 1'b0;
        bus.inst_data  = '0;
        bus.inst_pc    = '0;
        if (!w_empty) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = w_head.data;
            bus.inst_pc    = w_head.pc;
        end else if (w_byp) begin
            bus.inst_valid = 1'b1;
            bus.inst_data  = bus.rom_dout;
            bus.inst_pc    = r_fetch_pc;
        end
    end
`else
    // Pop frees a slot in the same cycle, so a full queue still streams
    assign w_push = !bus.redirect_valid && (!w_full || w_fifo_pop);
    assign w_adv  = w_push;

    // Head comes only from queue registers; zeros when empty
    always_comb begin
        bus.inst_valid = !w_empty;
        bus.inst_data  = w_empty ? '0 : w_head.data;
        bus.inst_pc    = w_empty ? '0 : w_head.pc;
    end
`endif

    // Fetch PC: reset, then redirect, then sequential advance when a word is taken
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_fetch_pc <= RESET_PC;
        else if (bus.redirect_valid)
            r_fetch_pc <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        else if (w_adv)
            r_fetch_pc <= r_fetch_pc + PC_W'(4);
    end

    // ROM address is purely a function of registered state
    assign bus.rom_adrs = pc_to_adrs(r_fetch_pc);

    ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (bus.redirect_valid),
        .i_push  (w_push),
        .i_wdata ('{pc: r_fetch_pc, data: bus.rom_dout}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed checks of ifetch_queue (default build, no bypass)
// against a small factorial ROM image modelled in the bench.
module tb_ifetch_queue;
    logic        clk;
    logic        rst_n;
    logic [31:0] rom [512];
    int          checks;
    int          passed;

    ifetch_queue_if u_if ();

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0040_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    // Combinational ROM model
    assign u_if.rom_dout = rom[u_if.rom_adrs];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        for (int i = 0; i < 512; i++) rom[i] = 32'hA500_0000 | i;
        rom[0]   = 32'h3c011001;
        rom[1]   = 32'h343d7ffc;
        rom[2]   = 32'h24100006;
        rom[3]   = 32'h24110001;
        rom[4]   = 32'h00102021;
        rom[10]  = 32'h23bdfff8;
        rom[511] = 32'h00000000;

        rst_n = 1'b0;
        u_if.redirect_valid = 1'b0;
        u_if.redirect_pc    = '0;
        u_if.inst_ready     = 1'b0;
        step();
        step();
        chk("rst_valid", {31'd0, u_if.inst_valid}, 32'd0);
        chk("rst_data",  u_if.inst_data, 32'd0);
        chk("rst_pc",    u_if.inst_pc,   32'd0);
        chk("rst_adrs",  {23'd0, u_if.rom_adrs}, 32'h000);

        // Streaming with inst_ready held high
        rst_n = 1'b1;
        u_if.inst_ready = 1'b1;
        step();
        chk("s0_valid", {31'd0, u_if.inst_valid}, 32'd1);
        chk("s0_pc",   u_if.inst_pc,   32'h0040_0000);
        chk("s0_data", u_if.inst_data, 32'h3c011001);
        step();
        chk("s1_pc",   u_if.inst_pc,   32'h0040_0004);
        chk("s1_data", u_if.inst_data, 32'h343d7ffc);
        step();
        chk("s2_pc",   u_if.inst_pc,   32'h0040_0008);
        chk("s2_data", u_if.inst_data, 32'h24100006);
        chk("s2_adrs", {23'd0, u_if.rom_adrs}, 32'h003);

        // Fill with decoder stalled, then drain without gaps
        rst_n = 1'b0;
        u_if.inst_ready = 1'b0;
        step();
        chk("r2_valid", {31'd0, u_if.inst_valid}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("full_adrs", {23'd0, u_if.rom_adrs}, 32'h004);
        chk("full_head", u_if.inst_data, 32'h3c011001);
        chk("full_pc",   u_if.inst_pc,   32'h0040_0000);
        u_if.inst_ready = 1'b1;
        #1;
        chk("d0_data", u_if.inst_data, 32'h3c011001);
        step();
        chk("d1_data", u_if.inst_data, 32'h343d7ffc);
        step();
        chk("d2_data", u_if.inst_data, 32'h24100006);
        step();
        chk("d3_data", u_if.inst_data, 32'h24110001);
        step();
        chk("d4_data", u_if.inst_data, 32'h00102021);
        chk("d4_valid", {31'd0, u_if.inst_valid}, 32'd1);

        // Redirect with three queued entries
        rst_n = 1'b0;
        u_if.inst_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("q3_adrs", {23'd0, u_if.rom_adrs}, 32'h003);
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h0040_0028;
        step();
        u_if.redirect_valid = 1'b0;
        chk("rd_flush_valid", {31'd0, u_if.inst_valid}, 32'd0);
        chk("rd_adrs", {23'd0, u_if.rom_adrs}, 32'h00a);
        step();
        chk("rd_pc",   u_if.inst_pc,   32'h0040_0028);
        chk("rd_data", u_if.inst_data, 32'h23bdfff8);
        u_if.inst_ready = 1'b1;
        step();
        chk("rd_next_pc", u_if.inst_pc, 32'h0040_002c);

        // Unaligned redirect together with a pop
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h0040_002b;
        step();
        u_if.redirect_valid = 1'b0;
        chk("ua_flush_valid", {31'd0, u_if.inst_valid}, 32'd0);
        step();
        chk("ua_pc",   u_if.inst_pc,   32'h0040_0028);
        chk("ua_data", u_if.inst_data, 32'h23bdfff8);

        // ROM address wrap at 0x004007fc -> 0x00400800
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h0040_07fc;
        step();
        u_if.redirect_valid = 1'b0;
        chk("wr_adrs_pre", {23'd0, u_if.rom_adrs}, 32'h1ff);
        step();
        chk("wr_pc0",   u_if.inst_pc,   32'h0040_07fc);
        chk("wr_data0", u_if.inst_data, 32'h0000_0000);
        chk("wr_adrs",  {23'd0, u_if.rom_adrs}, 32'h000);
        step();
        chk("wr_pc1",   u_if.inst_pc,   32'h0040_0800);
        chk("wr_data1", u_if.inst_data, 32'h3c011001);

        // Reset beats a pending redirect with a full queue
        u_if.inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_valid", {31'd0, u_if.inst_valid}, 32'd1);
        rst_n = 1'b0;
        u_if.redirect_valid = 1'b1;
        u_if.redirect_pc    = 32'h0040_0028;
        step();
        chk("mr_valid", {31'd0, u_if.inst_valid}, 32'd0);
        chk("mr_adrs",  {23'd0, u_if.rom_adrs}, 32'h000);
        chk("mr_data",  u_if.inst_data, 32'd0);
        rst_n = 1'b1;
        u_if.redirect_valid = 1'b0;
        u_if.inst_ready = 1'b1;
        step();
        chk("mr_pc0",   u_if.inst_pc,   32'h0040_0000);
        chk("mr_data0", u_if.inst_data, 32'h3c011001);
        step();
        chk("mr_pc1",   u_if.inst_pc,   32'h0040_0004);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
